// File: rtl/invaders_march.sv
// Invader formation sequencer: marches the block one column per step, drops a line at
// each edge, and speeds up as the alive count falls. Halts on game end or landing.
module invaders_march #(
  parameter int unsigned MIN_FRAMES = 2,
  parameter int unsigned X_MAX      = 12,
  parameter int unsigned LINE_MAX   = 14
) (
  input  logic        i_clk_25MHz,
  input  logic        i_reset,
  input  logic        i_frame_tick,
  input  logic [19:0] i_invaders_array,
  input  logic [1:0]  i_gameplay,
  output logic [4:0]  o_invaders_x,
  output logic [3:0]  o_invaders_line,
  output logic        o_direction,
  output logic        o_step,
  output logic        o_halted
);

  localparam logic [4:0] XMax    = 5'(X_MAX);
  localparam logic [3:0] LineMax = 4'(LINE_MAX);
  localparam logic [1:0] Playing = 2'b00;

  typedef enum logic [0:0] {StMove, StHalt} state_e;

  state_e     state_q;
  logic [5:0] frame_cnt_q;
  logic [4:0] x_q;
  logic [3:0] line_q;
  logic       dir_q;
  logic       step_q;
  logic       halted_q;

  logic [4:0] alive;
  logic [5:0] period;
  logic       period_done;
  logic       at_edge;
  logic       lands;

  always_comb begin
    alive = '0;
    for (int i = 0; i < 20; i++) begin
      alive = alive + 5'(i_invaders_array[i]);
    end
  end

  assign period = 6'(MIN_FRAMES) + {1'b0, alive};
  // Greater-or-equal so a mid-period shrink steps on the next tick rather than wrapping.
  assign period_done = ({1'b0, frame_cnt_q} + 7'd1) >= {1'b0, period};
  assign at_edge     = dir_q ? (x_q == 5'd0) : (x_q >= XMax);
  assign lands       = at_edge && ((line_q + 4'd1) >= LineMax);

  always_ff @(posedge i_clk_25MHz) begin
    if (i_reset) begin
      state_q     <= StMove;
      frame_cnt_q <= '0;
      x_q         <= '0;
      line_q      <= '0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      step_q <= 1'b0;
      unique case (state_q)
        StMove: begin
          if (i_gameplay != Playing || line_q >= LineMax) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else if (i_frame_tick) begin
            if (period_done) begin
              frame_cnt_q <= '0;
              step_q      <= 1'b1;
              if (at_edge) begin
                line_q <= (line_q >= LineMax) ? LineMax : line_q + 4'd1;
                dir_q  <= ~dir_q;
              end else if (dir_q) begin
                x_q <= x_q - 5'd1;
              end else begin
                x_q <= x_q + 5'd1;
              end
              if (lands) begin
                state_q  <= StHalt;
                halted_q <= 1'b1;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + 6'd1;
            end
          end
        end
        StHalt: begin
          if (i_gameplay == Playing && line_q < LineMax) begin
            state_q  <= StMove;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StHalt;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_invaders_x    = x_q;
  assign o_invaders_line = line_q;
  assign o_direction     = dir_q;
  assign o_step          = step_q;
  assign o_halted        = halted_q;

endmodule
